cr_ib_framer: RTL and testbench
===============================

Name: cr_ib_framer

Overview:
- Inbound AXI-Stream framing stage placed directly upstream of the cr_cceip_64 ib_* port.
- Takes 64-bit host words tagged with tuser codes: SoT=0x01, EoT=0x02, data=0x03, untagged=0x00.
- Tracks frame boundaries, asserts tlast on the EoT of each CQE frame (SoT word with data[7:0]==CQE_TYPE), drops orphan words and counts framing errors.
- Registered outputs through a 2-entry skid buffer; full throughput under continuous ready.

Parameters:
- DATA_W, 64, tdata width
- STRB_W, 8, tstrb width
- USER_W, 8, tuser width
- TID_W, 1, tid width
- CQE_TYPE, 8'h09, data[7:0] value on SoT marking a CQE frame
- ERR_CNT_W, 16, error counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_tvalid  in  1  upstream valid
- s_tready  out  1  upstream ready
- s_tdata  in  DATA_W  upstream data
- s_tstrb  in  STRB_W  upstream byte strobes
- s_tuser  in  USER_W  upstream word code
- s_tid  in  TID_W  upstream stream id
- m_tvalid  out  1  to engine ib_tvalid
- m_tready  in  1  from engine ib_tready
- m_tdata  out  DATA_W  to ib_tdata
- m_tstrb  out  STRB_W  to ib_tstrb
- m_tuser  out  USER_W  to ib_tuser
- m_tid  out  TID_W  to ib_tid
- m_tlast  out  1  to ib_tlast
- err_clr  in  1  clears err_cnt
- frame_active  out  1  FSM not in IDLE
- cqe_done  out  1  one-cycle pulse when a tlast word is accepted downstream
- err_cnt  out  ERR_CNT_W  saturating framing-error count

Behaviour:
Clock and reset:
- One clock, clk. rst_n is synchronous and active-low.
- Reset clears all state. After the reset cycle: m_tvalid=0, m_tlast=0, m_tdata/tstrb/tuser/tid=0, s_tready=1, frame_active=0, cqe_done=0, err_cnt=0.
- Reset mid-frame discards all buffered words; no partial frame is completed.

Handshake:
- Accept when s_tvalid&s_tready; downstream transfer when m_tvalid&m_tready.
- m_* outputs are held stable while m_tvalid=1 and m_tready=0.
- Skid buffer, entries main+skid. s_tready = !skid_full, driven from a register.
- Accepted word reaches m_* the next cycle if main is empty or being drained.
- Stall: the word lands in skid and s_tready drops the following cycle. Words drain in order.
- Latency 1 cycle; sustained 1 word/cycle when m_tready=1.

FSM, evaluated on each accepted word:
- IDLE:
  - SoT with data[7:0]==CQE_TYPE -> IN_CQE, forward.
  - SoT otherwise -> IN_FRAME, forward.
  - 0x00 -> forward, stay.
  - EoT/0x03 -> orphan: drop (not forwarded), err+1, stay.
- IN_FRAME:
  - 0x03/0x00 -> forward.
  - EoT -> forward with tlast=0, go IDLE.
  - SoT -> err+1, forward, re-enter per CQE test (the new frame starts).
- IN_CQE:
  - Same as IN_FRAME, except EoT is forwarded with tlast=1.
- Unknown tuser codes (>0x03) -> forward, err+1, no state change.
- tlast is computed at accept time and stored with the word.
- frame_active = (state != IDLE), registered.

Counters and status:
- err_cnt saturates at all-ones.
- err_clr has priority over increment in the same cycle (result 0).
- cqe_done=1 exactly in the cycle after m_tvalid&m_tready&m_tlast.
- tdata/tstrb/tid pass unmodified; no strobe checking.

Decomposition:
- Package cr_ib_framer_pkg holds:
  - tuser code constants TUSER_NONE=0x00, TUSER_SOT=0x01, TUSER_EOT=0x02, TUSER_DATA=0x03
  - FSM enum {IDLE, IN_FRAME, IN_CQE}
  - word struct {tdata, tstrb, tuser, tid, tlast}
- Sub-module cr_ib_skid_buf: generic 2-entry registered skid buffer on the word struct.
- The top level contains only the FSM, drop/err logic and status outputs.

Test Plan:
- CQE frame: SoT 0x..09, 3×0x03, EoT with m_tready=1 -> 5 words out, 1-cycle latency, tlast only on EoT, cqe_done pulses once, err_cnt=0.
- Non-CQE frame: SoT 0x..08, 0x03, EoT -> 3 words out, tlast never 1, frame_active returns to 0 after EoT.
- Backpressure:
  - Stream of 8 words; m_tready low for cycles 3-6 -> s_tready drops one cycle after the stall begins.
  - All 8 words arrive in order, none lost or duplicated; outputs stable during the stall.
- Orphans: EoT then 0x03 in IDLE -> neither forwarded, err_cnt=2. A following 0x00 word is forwarded.
- SoT 0x09 then SoT 0x08 then EoT -> err_cnt=1, 3 words forwarded, EoT tlast=0 (the second frame is non-CQE).
- Saturation and reset:
  - Force err_cnt to max, inject another orphan -> value holds at max.
  - Assert err_clr together with an orphan -> err_cnt=0.
  - rst_n low mid-CQE frame -> m_tvalid=0 the next cycle; a new SoT then restarts cleanly.

Source files
------------

// File: rtl/cr_ib_framer_pkg.sv
// Shared types and constants for the inbound framer and its skid buffer.
package cr_ib_framer_pkg;

  localparam int PKG_DATA_W = 64;
  localparam int PKG_STRB_W = 8;
  localparam int PKG_USER_W = 8;
  localparam int PKG_TID_W  = 1;

  // Host word codes carried on tuser
  localparam logic [7:0] TUSER_NONE = 8'h00;
  localparam logic [7:0] TUSER_SOT  = 8'h01;
  localparam logic [7:0] TUSER_EOT  = 8'h02;
  localparam logic [7:0] TUSER_DATA = 8'h03;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    IN_CQE   = 2'd2
  } state_e;

  // One buffered beat; tlast is decided when the word is accepted
  typedef struct packed {
    logic [PKG_DATA_W-1:0] tdata;
    logic [PKG_STRB_W-1:0] tstrb;
    logic [PKG_USER_W-1:0] tuser;
    logic [PKG_TID_W-1:0]  tid;
    logic                  tlast;
  } word_t;

endpackage

// File: rtl/cr_ib_skid_buf.sv
// Two-entry registered skid buffer: main drives the output, skid absorbs
// the one word that arrives in the cycle a stall begins.
module cr_ib_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire;

  // Ready comes straight from the skid-occupancy register
  assign in_ready_o  = !skid_vld_q;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i && !skid_vld_q;

  // Next-state: refill main from skid first, otherwise from input
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (skid_vld_q) begin
      if (out_ready_i) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_vld_q || out_ready_i) begin
        main_d     = in_data_i;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_data_i;
        skid_vld_d = 1'b1;
      end
    end else if (out_ready_i) begin
      main_vld_d = 1'b0;
    end
  end

  // Buffer state registers; reset discards everything held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/cr_ib_framer.sv
// Inbound framer: tracks SoT/EoT framing, marks tlast on CQE frame ends,
// drops orphan words and counts framing errors.
module cr_ib_framer
  import cr_ib_framer_pkg::*;
#(
  parameter int          DATA_W    = PKG_DATA_W,
  parameter int          STRB_W    = PKG_STRB_W,
  parameter int          USER_W    = PKG_USER_W,
  parameter int          TID_W     = PKG_TID_W,
  parameter logic [7:0]  CQE_TYPE  = 8'h09,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [DATA_W-1:0]    s_tdata,
  input  logic [STRB_W-1:0]    s_tstrb,
  input  logic [USER_W-1:0]    s_tuser,
  input  logic [TID_W-1:0]     s_tid,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DATA_W-1:0]    m_tdata,
  output logic [STRB_W-1:0]    m_tstrb,
  output logic [USER_W-1:0]    m_tuser,
  output logic [TID_W-1:0]     m_tid,
  output logic                 m_tlast,
  input  logic                 err_clr,
  output logic                 frame_active,
  output logic                 cqe_done,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e                state_q, state_d;
  logic                  active_q;
  logic                  cqe_done_q;
  logic [ERR_CNT_W-1:0]  err_q;
  logic                  accept, fwd, err_hit, last;
  logic                  is_sot, is_eot, is_none, is_unk, is_cqe;
  word_t                 in_word, out_word;

  assign accept  = s_tvalid && s_tready;
  assign is_none = (s_tuser == USER_W'(TUSER_NONE));
  assign is_sot  = (s_tuser == USER_W'(TUSER_SOT));
  assign is_eot  = (s_tuser == USER_W'(TUSER_EOT));
  assign is_unk  = (s_tuser >  USER_W'(TUSER_DATA));
  assign is_cqe  = (s_tdata[7:0] == CQE_TYPE);

  // Decode the offered word: forward/drop, error, tlast and next state
  always_comb begin
    state_d = state_q;
    fwd     = 1'b1;
    err_hit = 1'b0;
    last    = 1'b0;
    if (is_unk) begin
      err_hit = 1'b1;
    end else if (state_q == IDLE) begin
      if (is_sot) begin
        state_d = is_cqe ? IN_CQE : IN_FRAME;
      end else if (!is_none) begin
        fwd     = 1'b0;
        err_hit = 1'b1;
      end
    end else begin
      if (is_sot) begin
        err_hit = 1'b1;
        state_d = is_cqe ? IN_CQE : IN_FRAME;
      end else if (is_eot) begin
        last    = (state_q == IN_CQE);
        state_d = IDLE;
      end
    end
  end

  // Frame state advances only on accepted words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
    end else if (accept) begin
      state_q  <= state_d;
      active_q <= (state_d != IDLE);
    end
  end

  // Saturating error counter; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      err_q <= '0;
    end else if (accept && err_hit && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  // Pulse one cycle after a tlast beat leaves downstream
  always_ff @(posedge clk) begin
    if (!rst_n) cqe_done_q <= 1'b0;
    else        cqe_done_q <= m_tvalid && m_tready && m_tlast;
  end

  assign in_word = '{tdata: s_tdata, tstrb: s_tstrb, tuser: s_tuser,
                     tid: s_tid, tlast: last};

  cr_ib_skid_buf #(.W($bits(word_t))) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s_tvalid && fwd),
    .in_ready_o  (s_tready),
    .in_data_i   (in_word),
    .out_valid_o (m_tvalid),
    .out_ready_i (m_tready),
    .out_data_o  (out_word)
  );

  assign m_tdata      = out_word.tdata;
  assign m_tstrb      = out_word.tstrb;
  assign m_tuser      = out_word.tuser;
  assign m_tid        = out_word.tid;
  assign m_tlast      = out_word.tlast;
  assign frame_active = active_q;
  assign cqe_done     = cqe_done_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_cr_ib_framer.sv
// Bench for cr_ib_framer: table-driven framing vectors, scoreboard on the
// output stream, plus backpressure, saturation and reset sequences.
module tb_cr_ib_framer;

  localparam logic [7:0] U_NONE = 8'h00, U_SOT = 8'h01, U_EOT = 8'h02, U_DATA = 8'h03;
  localparam int EW = 4;  // narrow error counter so saturation is reachable

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_tvalid = 1'b0, s_tready;
  logic [63:0]    s_tdata = '0;
  logic [7:0]     s_tstrb = '0, s_tuser = '0;
  logic [0:0]     s_tid = '0;
  logic           m_tvalid, m_tready = 1'b1;
  logic [63:0]    m_tdata;
  logic [7:0]     m_tstrb, m_tuser;
  logic [0:0]     m_tid;
  logic           m_tlast;
  logic           err_clr = 1'b0;
  logic           frame_active, cqe_done;
  logic [EW-1:0]  err_cnt;

  cr_ib_framer #(.ERR_CNT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tuser(s_tuser), .s_tid(s_tid),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tstrb(m_tstrb), .m_tuser(m_tuser), .m_tid(m_tid), .m_tlast(m_tlast),
    .err_clr(err_clr), .frame_active(frame_active), .cqe_done(cqe_done),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d; logic [7:0] s; logic [7:0] u; logic [0:0] t; logic l;
  } exp_t;

  typedef struct {
    logic [7:0] u; logic [7:0] lo; bit fwd; bit last; int err; bit act;
  } vec_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  int   cqe_pulses = 0;
  bit   pend_done = 0, stall_prev = 0;
  exp_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pops, cqe_done model, stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_done  = 0;
      stall_prev = 0;
    end else begin
      chk("cqe_done", cqe_done, pend_done);
      if (cqe_done) cqe_pulses++;
      if (stall_prev) begin
        chk("stall_data", m_tdata, held.d);
        chk("stall_ctl", {m_tvalid, m_tstrb, m_tuser, m_tid, m_tlast},
            {1'b1, held.s, held.u, held.t, held.l});
      end
      pend_done = 0;
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) chk("extra_word", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", m_tdata, e.d);
          chk("out_ctl", {m_tstrb, m_tuser, m_tid, m_tlast}, {e.s, e.u, e.t, e.l});
        end
        pend_done = m_tlast;
      end
      stall_prev = m_tvalid && !m_tready;
      held = '{d: m_tdata, s: m_tstrb, u: m_tuser, t: m_tid, l: m_tlast};
    end
  end

  // Offer one word, wait for acceptance, queue expectation if forwarded
  task automatic send(input logic [7:0] u, input logic [63:0] d,
                      input bit fwd, input bit last, input bit lat);
    logic [7:0] s;
    logic [0:0] t;
    bit acc = 0, rdy;
    int n = 0;
    s = 8'($urandom);
    t = 1'($urandom);
    s_tvalid = 1'b1; s_tdata = d; s_tstrb = s; s_tuser = u; s_tid = t;
    while (!acc && n < 100) begin
      rdy = s_tready;
      @(posedge clk); #1;
      if (rdy) acc = 1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    else if (fwd) q.push_back('{d: d, s: s, u: u, t: t, l: last});
    if (acc && lat && fwd) begin
      chk("lat_vld", m_tvalid, 1);
      chk("lat_data", m_tdata, d);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{U_SOT,  8'h09, 1, 0, 0, 1};
    tbl[1]  = '{U_DATA, 8'h11, 1, 0, 0, 1};
    tbl[2]  = '{U_DATA, 8'h12, 1, 0, 0, 1};
    tbl[3]  = '{U_DATA, 8'h13, 1, 0, 0, 1};
    tbl[4]  = '{U_EOT,  8'h14, 1, 1, 0, 0};
    tbl[5]  = '{U_SOT,  8'h08, 1, 0, 0, 1};
    tbl[6]  = '{U_DATA, 8'h21, 1, 0, 0, 1};
    tbl[7]  = '{U_EOT,  8'h22, 1, 0, 0, 0};
    tbl[8]  = '{U_EOT,  8'h31, 0, 0, 1, 0};
    tbl[9]  = '{U_DATA, 8'h32, 0, 0, 2, 0};
    tbl[10] = '{U_NONE, 8'h33, 1, 0, 2, 0};
    tbl[11] = '{U_SOT,  8'h09, 1, 0, 2, 1};
    tbl[12] = '{U_SOT,  8'h08, 1, 0, 3, 1};
    tbl[13] = '{U_EOT,  8'h41, 1, 0, 3, 0};
    tbl[14] = '{8'h05,  8'h42, 1, 0, 4, 0};
    tbl[15] = '{U_SOT,  8'h09, 1, 0, 4, 1};
    tbl[16] = '{8'h7F,  8'h51, 1, 0, 5, 1};
    tbl[17] = '{U_EOT,  8'h52, 1, 1, 5, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_word", {m_tdata, m_tstrb, m_tuser, m_tid}, '0);
    chk("rst_s_tready", s_tready, 1);
    chk("rst_active", frame_active, 0);
    chk("rst_cqe_done", cqe_done, 0);
    chk("rst_err", err_cnt, 0);
    rst_n = 1'b1;

    // Framing table under continuous ready
    for (int i = 0; i < 18; i++) begin
      send(tbl[i].u, {8'(i), 48'h0123_4567_89AB, tbl[i].lo}, tbl[i].fwd, tbl[i].last, 1);
      chk($sformatf("tbl%0d_err", i), err_cnt, tbl[i].err);
      chk($sformatf("tbl%0d_act", i), frame_active, tbl[i].act);
    end
    drain();
    @(posedge clk); #1;
    chk("cqe_pulses", cqe_pulses, 2);

    // Backpressure: 8 words, m_tready low for 4 cycles starting at cycle 3
    fork
      begin
        for (int i = 0; i < 8; i++) send(U_NONE, 64'hB000_0000_0000_0000 | 64'(i), 1, 0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_tready = 1'b0;
        chk("bp_ready_before", s_tready, 1);
        @(posedge clk); #1;
        chk("bp_ready_drop", s_tready, 0);
        repeat (3) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    drain();

    // Saturation and clear priority
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr_err", err_cnt, 0);
    for (int i = 0; i < 15; i++) send(U_EOT, 64'(i), 0, 0, 0);
    chk("sat_max", err_cnt, 15);
    send(U_EOT, 64'hDEAD, 0, 0, 0);
    chk("sat_hold", err_cnt, 15);
    err_clr = 1'b1;
    send(U_DATA, 64'hBEEF, 0, 0, 0);
    err_clr = 1'b0;
    chk("clr_prio", err_cnt, 0);

    // Reset mid-CQE frame with words buffered
    m_tready = 1'b0;
    send(U_SOT, 64'hC0C0_0009, 1, 0, 0);
    send(U_DATA, 64'hC0C0_0010, 1, 0, 0);
    chk("pre_rst_ready", s_tready, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    chk("mid_rst_vld", m_tvalid, 0);
    chk("mid_rst_ready", s_tready, 1);
    chk("mid_rst_active", frame_active, 0);
    rst_n = 1'b1;
    m_tready = 1'b1;
    send(U_SOT, 64'hD0D0_0009, 1, 0, 1);
    send(U_EOT, 64'hD0D0_0011, 1, 1, 1);
    drain();
    @(posedge clk); #1;
    chk("post_rst_err", err_cnt, 0);
    chk("post_rst_active", frame_active, 0);
    chk("post_rst_cqe", cqe_pulses, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
